crypt_block_drain: RTL and testbench



---
 rtl/crypt_block_drain_if.sv | 28 ++
 rtl/crypt_block_drain.sv | 136 +++++++++++++
 tb/tb_crypt_block_drain.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/crypt_block_drain_if.sv
// Block-in / byte-out bundle for the crypt block drain.
// The slave modport is the drain itself; master is the environment around it.
interface crypt_block_drain_if #(
    parameter int BLOCK_BYTES = 16,
    parameter int BYTE_W      = 8,
    parameter int CNT_W       = 16
);
    logic                          abort;
    logic                          blk_valid;
    logic                          blk_ready;
    logic [BLOCK_BYTES*BYTE_W-1:0] blk_data;
    logic                          byte_valid;
    logic                          byte_ready;
    logic [BYTE_W-1:0]             byte_data;
    logic                          byte_last;
    logic                          busy;
    logic [CNT_W-1:0]              blk_count;

    modport slave (
        input  abort, blk_valid, blk_data, byte_ready,
        output blk_ready, byte_valid, byte_data, byte_last, busy, blk_count
    );

    modport master (
        output abort, blk_valid, blk_data, byte_ready,
        input  blk_ready, byte_valid, byte_data, byte_last, busy, blk_count
    );
endinterface

// File: rtl/crypt_block_drain.sv
// Serialises 128-bit cryptographer result blocks onto a byte stream, MSB byte first,
// with an active/pending double buffer so the next block can be handed off early.
module crypt_block_drain #(
    parameter int BLOCK_BYTES = 16,
    parameter int BYTE_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    crypt_block_drain_if.slave    bus
);
    localparam int DATA_W = BLOCK_BYTES * BYTE_W;
    localparam int IDX_W  = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_active;
    logic [DATA_W-1:0]   r_pend;
    logic                r_pend_full;
    logic [IDX_W-1:0]    r_idx;
    logic                r_byte_valid;
    logic [BYTE_W-1:0]   r_byte_data;
    logic                r_byte_last;
    logic                r_busy;
    logic [CNT_W-1:0]    r_blk_count;

    logic                w_blk_ready;
    logic                w_accept;
    logic                w_xfer;
    logic                w_last_xfer;
    logic [IDX_W-1:0]    w_idx_nxt;

    // Byte k of a block sits at the k-th byte down from the MSB.
    function automatic logic [BYTE_W-1:0] sel_byte(input logic [DATA_W-1:0] blk,
                                                  input logic [IDX_W-1:0]  k);
        return blk[(BLOCK_BYTES - 1 - int'(k)) * BYTE_W +: BYTE_W];
    endfunction

    assign w_blk_ready = !rst && !bus.abort && !r_pend_full;
    assign w_accept    = bus.blk_valid && w_blk_ready;
    assign w_xfer      = r_byte_valid && bus.byte_ready;
    assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);
    assign w_idx_nxt   = r_idx + IDX_W'(1);

    // Drain FSM, buffers, output byte register and completed-block counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_active     <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_idx        <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_byte_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_blk_count  <= '0;
        end else if (bus.abort) begin
            r_state      <= ST_IDLE;
            r_pend_full  <= 1'b0;
            r_idx        <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_byte_last  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_active     <= bus.blk_data;
                        r_idx        <= '0;
                        r_byte_valid <= 1'b1;
                        r_byte_data  <= sel_byte(bus.blk_data, '0);
                        r_byte_last  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SEND;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (w_last_xfer) begin
                        r_blk_count <= r_blk_count + CNT_W'(1);
                        r_idx       <= '0;
                        r_byte_last <= 1'b0;
                        // Refill from pending first; blk_ready is low then, so no accept clashes.
                        if (r_pend_full) begin
                            r_active    <= r_pend;
                            r_pend_full <= 1'b0;
                            r_byte_data <= sel_byte(r_pend, '0);
                        end else if (w_accept) begin
                            r_active    <= bus.blk_data;
                            r_byte_data <= sel_byte(bus.blk_data, '0);
                        end else begin
                            r_byte_valid <= 1'b0;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_idx       <= w_idx_nxt;
                            r_byte_data <= sel_byte(r_active, w_idx_nxt);
                            r_byte_last <= (w_idx_nxt == LAST_IDX);
                        end else begin
                            r_idx <= r_idx;
                        end
                        if (w_accept) begin
                            r_pend      <= bus.blk_data;
                            r_pend_full <= 1'b1;
                        end else begin
                            r_pend_full <= r_pend_full;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_valid <= 1'b0;
                    r_byte_last  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.blk_ready  = w_blk_ready;
    assign bus.byte_valid = r_byte_valid;
    assign bus.byte_data  = r_byte_data;
    assign bus.byte_last  = r_byte_last;
    assign bus.busy       = r_busy;
    assign bus.blk_count  = r_blk_count;
endmodule

// File: tb/tb_crypt_block_drain.sv
// Randomised and directed bench for crypt_block_drain against a queue-of-blocks model.
module tb_crypt_block_drain;
    logic clk;
    logic rst;

    crypt_block_drain_if #(.BLOCK_BYTES(16), .BYTE_W(8), .CNT_W(16)) bus ();

    crypt_block_drain #(.BLOCK_BYTES(16), .BYTE_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Model: blocks held by the drain (front = active), position in the front block, count.
    logic [127:0] m_blocks[$];
    int           m_pos;
    logic [15:0]  m_cnt;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hF0E0D0C0B0A090807060504030201000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_byte(input logic [127:0] b, input int k);
        return b[(15 - k) * 8 +: 8];
    endfunction

    // One clock: drive inputs, compare every output with the model, then advance the model.
    task automatic step(input logic v, input logic [127:0] d, input logic br,
                        input logic ab, input logic rs);
        logic acc;
        @(negedge clk);
        bus.blk_valid  = v;
        bus.blk_data   = d;
        bus.byte_ready = br;
        bus.abort      = ab;
        rst            = rs;
        #1;
        check_eq("blk_ready", 32'(bus.blk_ready), 32'(!rs && !ab && m_blocks.size() < 2));
        check_eq("byte_valid", 32'(bus.byte_valid), 32'(m_blocks.size() > 0));
        check_eq("busy", 32'(bus.busy), 32'(m_blocks.size() > 0));
        check_eq("blk_count", 32'(bus.blk_count), 32'(m_cnt));
        if (m_blocks.size() > 0) begin
            check_eq("byte_data", 32'(bus.byte_data), 32'(m_byte(m_blocks[0], m_pos)));
            check_eq("byte_last", 32'(bus.byte_last), 32'(m_pos == 15));
        end else begin
            check_eq("byte_last_idle", 32'(bus.byte_last), 32'd0);
        end
        acc = v && !ab && !rs && (m_blocks.size() < 2);
        @(posedge clk);
        if (rs) begin
            m_blocks.delete();
            m_pos = 0;
            m_cnt = 16'd0;
        end else if (ab) begin
            m_blocks.delete();
            m_pos = 0;
        end else begin
            if (m_blocks.size() > 0 && br) begin
                m_pos++;
                if (m_pos == 16) begin
                    void'(m_blocks.pop_front());
                    m_pos = 0;
                    m_cnt = m_cnt + 16'd1;
                end
            end
            if (acc) m_blocks.push_back(d);
        end
    endtask

    task automatic idle(input int n, input logic br);
        for (int i = 0; i < n; i++) step(1'b0, 128'd0, br, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_pos   = 0;
        m_cnt   = 16'd0;
        bus.blk_valid  = 1'b0;
        bus.blk_data   = 128'd0;
        bus.byte_ready = 1'b0;
        bus.abort      = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_byte_data", 32'(bus.byte_data), 32'd0);
        check_eq("reset_valid", 32'(bus.byte_valid), 32'd0);
        check_eq("reset_ready", 32'(bus.blk_ready), 32'd1);
        check_eq("reset_count", 32'(bus.blk_count), 32'd0);

        // Single block, consumer always ready.
        step(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
        idle(17, 1'b1);
        check_eq("single_count", 32'(bus.blk_count), 32'd1);

        // Backpressure with byte_ready pattern 1,0,0,1,0,0,...
        step(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 52; i++) step(1'b0, 128'd0, (i % 3) == 0, 1'b0, 1'b0);
        check_eq("bp_count", 32'(bus.blk_count), 32'd2);

        // Back-to-back: B lands in pending while A drains.
        step(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
        step(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
        idle(34, 1'b1);
        check_eq("b2b_count", 32'(bus.blk_count), 32'd4);

        // Same-cycle refill on A's last byte transfer.
        step(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
        idle(15, 1'b1);
        step(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
        idle(17, 1'b1);
        check_eq("refill_count", 32'(bus.blk_count), 32'd6);

        // Abort right after 0x55 is taken, then a fresh block.
        step(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);
        step(1'b0, 128'd0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        check_eq("abort_count", 32'(bus.blk_count), 32'd6);
        step(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
        idle(17, 1'b1);
        check_eq("post_abort_count", 32'(bus.blk_count), 32'd7);

        // Reset mid-block with pending full.
        step(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
        step(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 128'd0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        check_eq("reset_mid_count", 32'(bus.blk_count), 32'd0);

        // Random traffic including occasional abort and reset.
        for (int i = 0; i < 3000; i++) begin
            logic [127:0] rd;
            rd = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 1) == 1), rd, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) < 1));
        end
        idle(40, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
